// File: rtl/adder_scoreboard.sv
// rtl/adder_scoreboard.sv - expected-sum FIFO scoreboard for the 8-bit adder test
module adder_scoreboard #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  input  logic [WIDTH-1:0]           op_a,
  input  logic [WIDTH-1:0]           op_b,
  output logic                       op_ready,
  input  logic                       res_valid,
  input  logic [WIDTH:0]             res_data,
  output logic                       res_ready,
  output logic [CNT_W-1:0]           match_count,
  output logic [CNT_W-1:0]           mismatch_count,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       idle,
  output logic                       err_flag,
  output logic [1:0]                 err_code,
  output logic [WIDTH:0]             err_expected,
  output logic [WIDTH:0]             err_actual
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [WIDTH:0]  head;
  logic [WIDTH:0]  sum;
  logic            push;
  logic            pop;
  logic            underflow;
  logic            equal;

  // Occupancy comes from registered pointers only, so a same-cycle pop never frees a slot.
  assign pending   = wr_ptr - rd_ptr;
  assign idle      = (pending == '0);
  assign op_ready  = (pending != FULL_LVL);
  assign res_ready = 1'b1;

  assign sum       = {1'b0, op_a} + {1'b0, op_b};
  assign head      = mem[rd_ptr[AW-1:0]];
  assign equal     = (res_data == head);

  // A result with nothing queued is an underflow; there is no bypass from the push side.
  assign push      = op_valid & op_ready;
  assign pop       = res_valid & !idle;
  assign underflow = res_valid & idle;

  // Expected-value storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= sum;
    end
  end

  // Pointers, saturating counters and the sticky first-error record.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      match_count    <= '0;
      mismatch_count <= '0;
      err_flag       <= 1'b0;
      err_code       <= 2'd0;
      err_expected   <= '0;
      err_actual     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (equal) begin
          if (match_count != '1) match_count <= match_count + CNT_W'(1);
        end else begin
          if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
        end
      end
      if (!err_flag) begin
        if (pop && !equal) begin
          err_flag     <= 1'b1;
          err_code     <= 2'd1;
          err_expected <= head;
          err_actual   <= res_data;
        end else if (underflow) begin
          err_flag     <= 1'b1;
          err_code     <= 2'd2;
          err_expected <= '0;
          err_actual   <= res_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_scoreboard.sv
// tb/tb_adder_scoreboard.sv - directed scoreboard bench for adder_scoreboard
module tb_adder_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       op_ready;
  logic       res_valid = 1'b0;
  logic [8:0] res_data = '0;
  logic       res_ready;
  logic [3:0] match_count;
  logic [3:0] mismatch_count;
  logic [2:0] pending;
  logic       idle;
  logic       err_flag;
  logic [1:0] err_code;
  logic [8:0] err_expected;
  logic [8:0] err_actual;

  int cycle = 0;
  int tests = 0;
  int failed = 0;

  typedef struct packed {
    int         cyc;
    logic [3:0] m;
    logic [3:0] mm;
    logic [2:0] pend;
    logic       rdy;
    logic       ef;
    logic [1:0] ec;
    logic [8:0] ee;
    logic [8:0] ea;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];

  adder_scoreboard #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .pending(pending), .idle(idle),
    .err_flag(err_flag), .err_code(err_code),
    .err_expected(err_expected), .err_actual(err_actual)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Advance one clock edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic drive(input bit ov, input int a, input int b, input bit rv, input int r);
    op_valid  = ov;
    op_a      = 8'(a);
    op_b      = 8'(b);
    res_valid = rv;
    res_data  = 9'(r);
    tick();
  endtask

  task automatic push_op(input int a, input int b);
    drive(1'b1, a, b, 1'b0, 0);
  endtask

  task automatic give_res(input int r);
    drive(1'b0, 0, 0, 1'b1, r);
  endtask

  task automatic expect_st(input string nm, input int m, input int mm, input int pend,
                           input bit rdy, input bit ef, input int ec, input int ee, input int ea);
    exp_t e;
    e.cyc  = cycle;
    e.m    = 4'(m);
    e.mm   = 4'(mm);
    e.pend = 3'(pend);
    e.rdy  = rdy;
    e.ef   = ef;
    e.ec   = 2'(ec);
    e.ee   = 9'(ee);
    e.ea   = 9'(ea);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_st(nm, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  // Monitor: compares queued expectations against DUT state mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        tests++;
        if (match_count !== e.m || mismatch_count !== e.mm || pending !== e.pend ||
            idle !== (e.pend == 3'd0) || op_ready !== e.rdy || res_ready !== 1'b1 ||
            err_flag !== e.ef || err_code !== e.ec || err_expected !== e.ee ||
            err_actual !== e.ea) begin
          failed++;
          $display("FAIL %s: got m=%0d mm=%0d pend=%0d idle=%0b rdy=%0b res_rdy=%0b ef=%0b ec=%0d ee=%h ea=%h | want m=%0d mm=%0d pend=%0d idle=%0b rdy=%0b res_rdy=1 ef=%0b ec=%0d ee=%h ea=%h",
                   nm, match_count, mismatch_count, pending, idle, op_ready, res_ready,
                   err_flag, err_code, err_expected, err_actual,
                   e.m, e.mm, e.pend, (e.pend == 3'd0), e.rdy, e.ef, e.ec, e.ee, e.ea);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    tick();

    // In-order traffic, no errors
    do_reset("t1_reset");
    push_op(1, 2);
    expect_st("t1_push1", 0, 0, 1, 1'b1, 1'b0, 0, 0, 0);
    push_op(3, 4);
    push_op(8'hFF, 8'h01);
    expect_st("t1_push3", 0, 0, 3, 1'b1, 1'b0, 0, 0, 0);
    give_res(9'h003);
    give_res(9'h007);
    give_res(9'h100);
    expect_st("t1_done", 3, 0, 0, 1'b1, 1'b0, 0, 0, 0);

    // Carry width and mismatch capture
    do_reset("t2_reset");
    push_op(8'hFF, 8'hFF);
    expect_st("t2_push", 0, 0, 1, 1'b1, 1'b0, 0, 0, 0);
    give_res(9'h0FE);
    expect_st("t2_mismatch", 0, 1, 0, 1'b1, 1'b1, 1, 9'h1FE, 9'h0FE);
    push_op(8'hFF, 8'hFF);
    give_res(9'h1FE);
    expect_st("t2_sticky", 1, 1, 0, 1'b1, 1'b1, 1, 9'h1FE, 9'h0FE);

    // Full and back-pressure
    do_reset("t3_reset");
    push_op(1, 1);
    push_op(2, 2);
    push_op(3, 3);
    push_op(4, 4);
    expect_st("t3_full", 0, 0, 4, 1'b0, 1'b0, 0, 0, 0);
    push_op(5, 5);
    expect_st("t3_rejected", 0, 0, 4, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 5, 5, 1'b1, 2);
    expect_st("t3_pop_at_full", 1, 0, 3, 1'b1, 1'b0, 0, 0, 0);
    drive(1'b1, 6, 6, 1'b1, 4);
    expect_st("t3_push_pop", 2, 0, 3, 1'b1, 1'b0, 0, 0, 0);
    give_res(6);
    give_res(8);
    give_res(12);
    expect_st("t3_drain", 5, 0, 0, 1'b1, 1'b0, 0, 0, 0);

    // Underflow with same-cycle push
    do_reset("t4_reset");
    drive(1'b1, 2, 3, 1'b1, 9'h005);
    expect_st("t4_underflow", 0, 0, 1, 1'b1, 1'b1, 2, 0, 9'h005);
    give_res(9'h005);
    expect_st("t4_match", 1, 0, 0, 1'b1, 1'b1, 2, 0, 9'h005);
    give_res(9'h009);
    expect_st("t4_second_uf", 1, 0, 0, 1'b1, 1'b1, 2, 0, 9'h005);

    // Counter saturation at 4 bits
    do_reset("t5_reset");
    for (int i = 0; i < 17; i++) begin
      push_op(i, 1);
      give_res(i + 1);
      if (i == 13) expect_st("t5_count14", 14, 0, 0, 1'b1, 1'b0, 0, 0, 0);
    end
    expect_st("t5_saturated", 15, 0, 0, 1'b1, 1'b0, 0, 0, 0);

    // Reset mid-operation
    do_reset("t6_reset");
    give_res(7);
    push_op(1, 1);
    push_op(2, 2);
    push_op(3, 3);
    expect_st("t6_loaded", 0, 0, 3, 1'b1, 1'b1, 2, 0, 7);
    rst = 1'b1;
    drive(1'b1, 1, 1, 1'b1, 2);
    rst = 1'b0;
    expect_st("t6_after_rst", 0, 0, 0, 1'b1, 1'b0, 0, 0, 0);
    push_op(1, 1);
    give_res(2);
    expect_st("t6_fresh", 1, 0, 0, 1'b1, 1'b0, 0, 0, 0);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
